// File: rtl/prbs31_pkg.sv
// Shared constants and state type for the PRBS31 (x^31 + x^28 + 1) pattern checker.
package prbs31_pkg;
  localparam int POLY_TAP_A = 30;
  localparam int POLY_TAP_B = 27;
  localparam int PRBS_LEN = 31;
  localparam logic [30:0] SEED_VALUE = 31'd1;

  typedef enum logic {
    SEED   = 1'b0,
    LOCKED = 1'b1
  } state_t;
endpackage

// File: rtl/prbs31_sat_counter.sv
// Saturating up-counter; a clear on the same edge as an increment yields one.
module prbs31_sat_counter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [DATA_W-1:0] count
);
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      count <= '0;
    else if (clr)
      count <= {{(DATA_W-1){1'b0}}, inc};
    else if (inc)
      count <= sat_inc(count);
  end
endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 receiver: seeds its history from the line, then
// checks each bit against the regenerated sequence and tracks loss of sync.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int ERR_W       = 16,
  parameter int BIT_W       = 24,
  parameter int LOSS_WIN    = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_lost,
  output logic [ERR_W-1:0] err_count,
  output logic [BIT_W-1:0] bit_count
);
  localparam int WIN_W = $clog2(LOSS_WIN + 1);
  localparam logic [WIN_W-1:0] WIN_V    = WIN_W'(LOSS_WIN);
  localparam logic [WIN_W-1:0] THRESH_V = WIN_W'(LOSS_THRESH);
  localparam logic [4:0] SEED_MAX  = 5'(PRBS_LEN);
  localparam logic [4:0] SEED_LOCK = 5'(PRBS_LEN - 1);

  state_t              state, state_nxt;
  logic [PRBS_LEN-1:0] hist, hist_nxt;
  logic [4:0]          seed_cnt, seed_cnt_nxt;
  logic [WIN_W-1:0]    win_cnt, win_cnt_nxt, win_err, win_err_nxt;
  logic                pred, chk_vld, mism, err_nxt, lost_nxt;

  assign pred    = hist[POLY_TAP_A] ^ hist[POLY_TAP_B];
  assign chk_vld = bit_valid && (state == LOCKED);
  assign mism    = chk_vld && (bit_in != pred);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      state <= SEED;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    hist_nxt     = hist;
    seed_cnt_nxt = seed_cnt;
    win_cnt_nxt  = win_cnt;
    win_err_nxt  = win_err;
    err_nxt      = 1'b0;
    lost_nxt     = 1'b0;
    if (bit_valid) begin
      case (state)
        SEED: begin
          hist_nxt = {hist[PRBS_LEN-2:0], bit_in};
          if (seed_cnt != SEED_MAX)
            seed_cnt_nxt = seed_cnt + 5'd1;
          // Any history at or above the minimal generator seed is nonzero: no lock on a dead line.
          if (seed_cnt >= SEED_LOCK && hist_nxt >= SEED_VALUE)
            state_nxt = LOCKED;
        end
        LOCKED: begin
          // The prediction, not the received bit, feeds back so one bad bit counts once.
          hist_nxt    = {hist[PRBS_LEN-2:0], pred};
          err_nxt     = mism;
          win_cnt_nxt = win_cnt + 1'b1;
          win_err_nxt = win_err + {{(WIN_W-1){1'b0}}, mism};
          if (mism && win_err_nxt == THRESH_V) begin
            state_nxt    = SEED;
            seed_cnt_nxt = '0;
            win_cnt_nxt  = '0;
            win_err_nxt  = '0;
            lost_nxt     = 1'b1;
          end else if (win_cnt_nxt == WIN_V) begin
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end
        end
        default: state_nxt = SEED;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hist      <= '0;
      seed_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      hist      <= hist_nxt;
      seed_cnt  <= seed_cnt_nxt;
      win_cnt   <= win_cnt_nxt;
      win_err   <= win_err_nxt;
      err_pulse <= err_nxt;
      sync_lost <= lost_nxt;
    end
  end

  prbs31_sat_counter #(.DATA_W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (mism),
    .count (err_count)
  );

  prbs31_sat_counter #(.DATA_W(BIT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (chk_vld),
    .count (bit_count)
  );
endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: a sequence-level reference model predicts
// every cycle's outputs, a monitor compares them against the DUT.
module tb_prbs31_checker;
  localparam int ERR_W = 16;
  localparam int BIT_W = 24;
  localparam int LOSS_WIN = 64;
  localparam int LOSS_THRESH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic clr_cnt = 1'b0;
  logic locked, err_pulse, sync_lost;
  logic [ERR_W-1:0] err_count;
  logic [BIT_W-1:0] bit_count;

  prbs31_checker #(
    .ERR_W(ERR_W), .BIT_W(BIT_W), .LOSS_WIN(LOSS_WIN), .LOSS_THRESH(LOSS_THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .sync_lost(sync_lost),
    .err_count(err_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit err_pulse;
    bit sync_lost;
    longint err_count;
    longint bit_count;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Generator sequence from its reset: 30 zeros, a one, then b[n] = b[n-28] ^ b[n-31].
  bit gen_seq[$];
  int g = 0;
  function automatic bit gen_bit(int n);
    while (gen_seq.size() <= n) begin
      int k;
      k = gen_seq.size();
      if (k < 30) gen_seq.push_back(1'b0);
      else if (k == 30) gen_seq.push_back(1'b1);
      else gen_seq.push_back(gen_seq[k-28] ^ gen_seq[k-31]);
    end
    return gen_seq[n];
  endfunction

  // Reference model: last 31 bits of the local sequence (index 0 = oldest).
  bit m_locked;
  bit m_hist[$];
  int m_seed, m_wbits, m_werr;
  longint m_err, m_bits;

  function automatic void model_reset();
    m_locked = 0;
    m_hist.delete();
    repeat (31) m_hist.push_back(1'b0);
    m_seed = 0; m_wbits = 0; m_werr = 0; m_err = 0; m_bits = 0;
  endfunction

  function automatic exp_t model_step(bit v, bit b, bit clr);
    exp_t e;
    bit p, any;
    e.err_pulse = 0;
    e.sync_lost = 0;
    if (clr) begin m_err = 0; m_bits = 0; end
    if (v) begin
      if (!m_locked) begin
        m_hist.push_back(b);
        void'(m_hist.pop_front());
        if (m_seed < 31) m_seed++;
        any = 0;
        foreach (m_hist[i]) any |= m_hist[i];
        if (m_seed == 31 && any) m_locked = 1;
      end else begin
        p = m_hist[3] ^ m_hist[0];
        m_hist.push_back(p);
        void'(m_hist.pop_front());
        if (m_bits < (64'd1 << BIT_W) - 1) m_bits++;
        m_wbits++;
        if (b != p) begin
          if (m_err < (64'd1 << ERR_W) - 1) m_err++;
          e.err_pulse = 1;
          m_werr++;
        end
        if (m_werr == LOSS_THRESH) begin
          m_locked = 0; e.sync_lost = 1; m_seed = 0; m_wbits = 0; m_werr = 0;
        end else if (m_wbits == LOSS_WIN) begin
          m_wbits = 0; m_werr = 0;
        end
      end
    end
    e.locked = m_locked;
    e.err_count = m_err;
    e.bit_count = m_bits;
    return e;
  endfunction

  function automatic void chk(string name, longint act, longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  // Monitor: one expected entry per clock edge that followed a driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n == 1'b0 && sb.size() > 0) begin
        e = sb.pop_front();
        chk("locked", locked, e.locked);
        chk("err_pulse", err_pulse, e.err_pulse);
        chk("sync_lost", sync_lost, e.sync_lost);
        chk("err_count", err_count, e.err_count);
        chk("bit_count", bit_count, e.bit_count);
      end
    end
  end

  task automatic drive(bit v, bit b, bit c);
    @(negedge clk);
    bit_valid = v;
    bit_in = b;
    clr_cnt = c;
    sb.push_back(model_step(v, b, c));
  endtask

  task automatic send_one(bit flip, bit c);
    drive(1'b1, gen_bit(g) ^ flip, c);
    g++;
  endtask

  task automatic send_clean(int n);
    repeat (n) send_one(1'b0, 1'b0);
  endtask

  task automatic send_errs(int n, bit [63:0] mask);
    for (int i = 0; i < n; i++) send_one(mask[i], 1'b0);
  endtask

  task automatic align_window();
    while (m_locked && m_wbits != 0) send_clean(1);
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk);
      #3;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(string tag);
    @(posedge clk);
    #5;
    rst_n = 1'b1;
    bit_valid = 1'b0;
    clr_cnt = 1'b0;
    #1;
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err_pulse"}, err_pulse, 0);
    chk({tag, "_sync_lost"}, sync_lost, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_bit_count"}, bit_count, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [63:0] m7, m8;
    m7 = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 20) | (64'd1 << 30) |
         (64'd1 << 40) | (64'd1 << 50) | (64'd1 << 60);
    m8 = (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 9) | (64'd1 << 14) |
         (64'd1 << 20) | (64'd1 << 27) | (64'd1 << 35) | (64'd1 << 44);
    model_reset();

    #12;
    chk("reset_locked", locked, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_bit_count", bit_count, 0);
    @(negedge clk);
    rst_n = 1'b0;

    // Acquire on the generator stream, then a long clean run.
    g = 0;
    send_clean(30);
    drain();
    chk("prelock_locked", locked, 0);
    send_clean(1);
    drain();
    chk("lock_after_31", locked, 1);
    send_clean(10000);
    drain();
    chk("clean_err_count", err_count, 0);
    chk("clean_bit_count", bit_count, 10000);

    // Single flipped bit counts once and does not propagate.
    send_errs(64, 64'd1 << 10);
    send_clean(200);
    drain();
    chk("single_err_count", err_count, 1);
    chk("single_locked", locked, 1);

    // clr_cnt on a clean checked bit leaves bit_count at one.
    send_one(1'b0, 1'b1);
    drain();
    chk("clr_bit_count", bit_count, 1);
    chk("clr_err_count", err_count, 0);

    // Seven errors per window for five windows keeps lock.
    align_window();
    repeat (5) send_errs(64, m7);
    drain();
    chk("seven_err_count", err_count, 35);
    chk("seven_locked", locked, 1);

    // Eight errors inside one window drop sync, then re-acquire.
    send_one(1'b0, 1'b1);
    align_window();
    send_errs(45, m8);
    drain();
    chk("loss_err_count", err_count, 8);
    chk("loss_locked", locked, 0);
    send_clean(30);
    drain();
    chk("relock_early", locked, 0);
    send_clean(1);
    drain();
    chk("relock", locked, 1);

    // Reset while locked, then a dead line must not lock.
    do_reset("midlock");
    repeat (200) drive(1'b1, 1'b0, 1'b0);
    drain();
    chk("dead_locked", locked, 0);
    chk("dead_err_count", err_count, 0);
    g = 0;
    send_clean(31);
    drain();
    chk("dead_relock", locked, 1);

    // Gapped valid with random idle bits.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      else send_clean(1);
    end
    drain();
    chk("gapped_err_count", err_count, 0);
    chk("gapped_locked", locked, 1);

    // Clear coincident with an error leaves one.
    send_one(1'b1, 1'b1);
    drain();
    chk("clr_with_err", err_count, 1);

    do_reset("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
Serial PRBS31 receiver/checker, the far end of the team's x^31+x^28+1 pattern generator. It self-synchronises to an incoming bitstream and then counts bit errors against a locally regenerated sequence. It detects loss of sync and re-acquires automatically. It sits behind a pin or loopback path in the Tiny Tapeout wrapper and drives status and counters to the output pins.

Parameters:
ERR_W, 16, width of saturating error counter
BIT_W, 24, width of saturating checked-bit counter
LOSS_WIN, 64, window length in checked bits for loss-of-sync evaluation
LOSS_THRESH, 8, errors within one window that declare loss of sync (1..LOSS_WIN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high (asserted when 1)
bit_in  in  1  received serial bit
bit_valid  in  1  bit_in is sampled on this clk edge
clr_cnt  in  1  synchronous clear of err_count and bit_count
locked  out  1  checker in LOCKED state
err_pulse  out  1  one-cycle pulse, previous valid bit mismatched
sync_lost  out  1  one-cycle pulse on LOCKED->SEED transition
err_count  out  ERR_W  saturating mismatch count
bit_count  out  BIT_W  saturating count of bits checked in LOCKED

Behaviour:
- Reset (rst_n=1, async): state=SEED, hist[30:0]=0, seed_cnt=0, window counters=0, all outputs 0.
- hist[0] holds the newest bit. Prediction pred = hist[27] ^ hist[30], giving recurrence b[n]=b[n-28]^b[n-31], identical to the generator.
- All state advances only on clk edges with bit_valid=1. When bit_valid=0, everything holds and err_pulse/sync_lost are 0.
- SEED state:
  - Shift the received bit into hist (hist <= {hist[29:0], bit_in}); no compare.
  - seed_cnt increments up to 31 and saturates there.
  - Transition to LOCKED on the valid edge where seed_cnt==30, or seed_cnt==31 and already saturated, provided the new hist value is nonzero.
  - If the new hist is all-zero, stay in SEED and keep shifting. This blocks lock on a dead line.
- LOCKED state:
  - Compare bit_in with pred. Shift pred (not bit_in) into hist, so a single-bit error counts once and does not propagate.
  - Mismatch: err_pulse=1 on the next cycle (1-cycle registered latency); err_count+1, saturating at all ones.
  - Every checked bit: bit_count+1, saturating.
  - Window: win_cnt counts checked bits and win_err counts mismatches.
    - If win_err would reach LOSS_THRESH: next state=SEED, seed_cnt=0, window counters cleared, sync_lost pulse, locked falls the next cycle. The error that crossed the threshold is still counted.
    - Otherwise, when win_cnt reaches LOSS_WIN, both window counters clear.
- locked is registered and equals (state==LOCKED).
- clr_cnt:
  - Clears err_count and bit_count only; it does not affect state or the window.
  - If it coincides with a counted event, the counted value after the edge is 1 (the clear applies first, then the event).
- Reset mid-stream: immediate return to SEED. Re-lock needs 31 fresh valid bits.

Decomposition:
- Shared package prbs31_pkg:
  - POLY_TAP_A=30, POLY_TAP_B=27, PRBS_LEN=31, SEED_VALUE=31'd1.
  - State enum {SEED, LOCKED}.
- One natural sub-module, prbs31_sat_counter (parameterised width, inc, clr, clr-then-inc priority), instantiated twice.

Test Plan:
- Generator stream from its reset (30 zeros, then 1): locked=1 one cycle after the 31st valid bit. Over 10000 further bits, err_count=0 and bit_count=10000.
- After lock, flip one bit: exactly one err_pulse, err_count=1, locked stays 1, and the following bits produce no errors.
- Constant-0 input for 200 bits -> locked stays 0, err_count=0. Then switch to a generator stream -> locked rises after 31 bits of a nonzero history.
- After lock, inject 8 errors within 64 bits -> sync_lost pulse on the 8th, err_count=8, locked=0. Clean stream continues -> relock 31 bits later.
- 7 errors per 64-bit window spread over 5 windows -> never loses lock, err_count=35.
- bit_valid toggled 1/0 randomly -> identical lock and count results as contiguous valid. clr_cnt coincident with an error -> err_count=1. Assert rst_n mid-lock -> all outputs 0 asynchronously.
